// File: rtl/syncro_pkg.sv
// Shared synchronizer definitions: hall debounce FSM states and sensor polarity.
package syncro_pkg;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    DB_ACT = 2'd1,
    ACT    = 2'd2,
    DB_REL = 2'd3
  } hall_state_e;

  localparam logic HALL_ACTIVE = 1'b0;

endpackage

// File: rtl/hall_tick_gen_if.sv
// Hall tick generator bus: raw sensor in, tick/period/status out.
interface hall_tick_gen_if #(
  parameter int PERIOD_WIDTH = 24
);
  logic                    hall_n;
  logic                    turn_tick;
  logic [PERIOD_WIDTH-1:0] turn_period;
  logic                    period_valid;
  logic                    stall;

  modport master (output hall_n, input turn_tick, turn_period, period_valid, stall);
  modport slave  (input hall_n, output turn_tick, turn_period, period_valid, stall);
endinterface

// File: rtl/sync_ff.sv
// Generic flop-chain synchronizer for asynchronous single-bit inputs.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chain <= {STAGES{RST_VAL}};
    else      r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/hall_tick_gen.sv
// Debounces a hall sensor, emits one tick per turn and measures the turn period.
//   state  | meaning
//   REL    | magnet absent, waiting for an active sample
//   DB_ACT | active level seen, counting stable samples
//   ACT    | magnet present, turn already evaluated
//   DB_REL | release level seen, counting stable samples
module hall_tick_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int MIN_PERIOD      = 4096,
  parameter int PERIOD_WIDTH    = 24
) (
  input logic            clk,
  input logic            rst,
  hall_tick_gen_if.slave bus
);
  import syncro_pkg::*;

  localparam int                      DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]         DB_LOAD  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] PCNT_MAX = '1;
  localparam logic [PERIOD_WIDTH:0]   MIN_CMP  = (PERIOD_WIDTH + 1)'(MIN_PERIOD);

  logic                    w_hs;
  hall_state_e             r_state, w_state_nxt;
  logic [DB_W-1:0]         r_db_cnt, w_db_cnt_nxt;
  logic                    w_cand;
  logic                    w_accept;
  logic [PERIOD_WIDTH:0]   w_pcnt_inc;
  logic [PERIOD_WIDTH-1:0] r_pcnt;
  logic                    r_turn_tick;
  logic [PERIOD_WIDTH-1:0] r_turn_period;
  logic                    r_period_valid;
  logic                    r_stall;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(!HALL_ACTIVE)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.hall_n),
    .o_q (w_hs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= REL;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  // Debounce timer is a down-counter loaded on entry; terminal count is zero.
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_cand       = 1'b0;
    case (r_state)
      REL: if (w_hs == HALL_ACTIVE) begin
        w_state_nxt  = DB_ACT;
        w_db_cnt_nxt = DB_LOAD;
      end
      DB_ACT: if (w_hs != HALL_ACTIVE) begin
        w_state_nxt  = REL;
        w_db_cnt_nxt = '0;
      end else if (r_db_cnt == '0) begin
        w_state_nxt  = ACT;
        w_cand       = 1'b1;
      end else begin
        w_db_cnt_nxt = r_db_cnt - 1'b1;
      end
      ACT: if (w_hs != HALL_ACTIVE) begin
        w_state_nxt  = DB_REL;
        w_db_cnt_nxt = DB_LOAD;
      end
      DB_REL: if (w_hs == HALL_ACTIVE) begin
        w_state_nxt  = ACT;
        w_db_cnt_nxt = '0;
      end else if (r_db_cnt == '0) begin
        w_state_nxt  = REL;
      end else begin
        w_db_cnt_nxt = r_db_cnt - 1'b1;
      end
      default: w_state_nxt = REL;
    endcase
  end

  assign w_pcnt_inc = {1'b0, r_pcnt} + 1'b1;
  assign w_accept   = w_cand && (r_stall || (w_pcnt_inc >= MIN_CMP));

  // The first tick after a stall only re-arms the measurement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt         <= '0;
      r_turn_tick    <= 1'b0;
      r_turn_period  <= '0;
      r_period_valid <= 1'b0;
      r_stall        <= 1'b1;
    end else begin
      r_turn_tick <= w_accept;
      if (w_accept) begin
        r_pcnt  <= '0;
        r_stall <= 1'b0;
        if (!r_stall) begin
          r_turn_period  <= w_pcnt_inc[PERIOD_WIDTH-1:0];
          r_period_valid <= 1'b1;
        end
      end else if (r_pcnt != PCNT_MAX) begin
        r_pcnt <= w_pcnt_inc[PERIOD_WIDTH-1:0];
        if (w_pcnt_inc[PERIOD_WIDTH-1:0] == PCNT_MAX) begin
          r_stall        <= 1'b1;
          r_period_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.turn_tick    = r_turn_tick;
  assign bus.turn_period  = r_turn_period;
  assign bus.period_valid = r_period_valid;
  assign bus.stall        = r_stall;

endmodule

// File: tb/tb_hall_tick_gen.sv
// Self-checking bench for hall_tick_gen: pulse table, status probes, tick scoreboard.
module tb_hall_tick_gen;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int MP = 100;
  localparam int PW = 10;
  localparam int LAT = SS + DB + 1;

  typedef struct {
    int start;
    int width;
    bit tick;
    int period;
    bit valid;
  } pulse_t;

  typedef struct {
    int cyc;
    bit stall;
    bit valid;
    int period;
  } probe_t;

  typedef struct {
    int cyc;
    int period;
    bit valid;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  bit   prev_tick;

  pulse_t pulses[$];
  probe_t probes[$];
  exp_t   sb[$];

  hall_tick_gen_if #(.PERIOD_WIDTH(PW)) bus ();

  hall_tick_gen #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .MIN_PERIOD      (MP),
    .PERIOD_WIDTH    (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic pulse_t mk_pulse(int s, int w, bit t, int p, bit v);
    pulse_t r;
    r.start = s; r.width = w; r.tick = t; r.period = p; r.valid = v;
    return r;
  endfunction

  function automatic probe_t mk_probe(int c, bit s, bit v, int p);
    probe_t r;
    r.cyc = c; r.stall = s; r.valid = v; r.period = p;
    return r;
  endfunction

  function automatic exp_t mk_exp(int c, int p, bit v);
    exp_t r;
    r.cyc = c; r.period = p; r.valid = v;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive_pulses();
    foreach (pulses[i]) begin
      wait_cyc(pulses[i].start - 1);
      bus.hall_n = 1'b0;
      if (pulses[i].tick)
        sb.push_back(mk_exp(pulses[i].start + LAT, pulses[i].period, pulses[i].valid));
      wait_cyc(pulses[i].start + pulses[i].width - 1);
      bus.hall_n = 1'b1;
    end
  endtask

  task automatic run_probes();
    foreach (probes[i]) begin
      wait_cyc(probes[i].cyc);
      chk("probe_stall",  int'(bus.stall),        int'(probes[i].stall));
      chk("probe_valid",  int'(bus.period_valid), int'(probes[i].valid));
      chk("probe_period", int'(bus.turn_period),  probes[i].period);
      chk("probe_tick",   int'(bus.turn_tick),    0);
    end
  endtask

  // Every tick seen on the bus must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.turn_tick) begin
      chk("tick_not_back_to_back", int'(prev_tick), 0);
      if (sb.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tick_cycle",   cyc,                    e.cyc);
        chk("tick_period",  int'(bus.turn_period),  e.period);
        chk("tick_valid",   int'(bus.period_valid), int'(e.valid));
        chk("tick_stall",   int'(bus.stall),        0);
      end
    end
    prev_tick <= rst && bus.turn_tick;
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst        = 1'b0;
    bus.hall_n = 1'b1;

    // start, width, tick expected, turn_period at tick, period_valid at tick
    pulses.push_back(mk_pulse(  10, 50, 1,   0, 0));  // first tick only arms
    pulses.push_back(mk_pulse( 510, 50, 1, 500, 1));
    pulses.push_back(mk_pulse(1010, 50, 1, 500, 1));
    pulses.push_back(mk_pulse(1200,  3, 0,   0, 0));  // short glitch
    pulses.push_back(mk_pulse(1300,  3, 0,   0, 0));  // bounce: low 3, high 1, low 3
    pulses.push_back(mk_pulse(1304,  3, 0,   0, 0));
    pulses.push_back(mk_pulse(1510, 50, 1, 500, 1));
    pulses.push_back(mk_pulse(1570, 20, 0,   0, 0));  // 60 cycles after tick: rejected
    pulses.push_back(mk_pulse(2010, 50, 1, 500, 1));
    pulses.push_back(mk_pulse(3100, 50, 1, 500, 0));  // after stall: re-arm only
    pulses.push_back(mk_pulse(3500, 50, 1, 400, 1));

    // cycle, stall, period_valid, turn_period
    probes.push_back(mk_probe(   1, 1, 0,   0));
    probes.push_back(mk_probe(  16, 1, 0,   0));
    probes.push_back(mk_probe(  18, 0, 0,   0));
    probes.push_back(mk_probe( 518, 0, 1, 500));
    probes.push_back(mk_probe(1600, 0, 1, 500));
    probes.push_back(mk_probe(3039, 0, 1, 500));
    probes.push_back(mk_probe(3040, 1, 0, 500));
    probes.push_back(mk_probe(3108, 0, 0, 500));

    repeat (3) @(negedge clk);
    rst = 1'b1;

    fork
      drive_pulses();
      run_probes();
    join

    wait_cyc(3600);
    chk("missing_ticks_main", sb.size(), 0);

    // Reset in the middle of an assert debounce.
    wait_cyc(3699);
    bus.hall_n = 1'b0;
    wait_cyc(3705);
    rst = 1'b0;
    #1;
    chk("rst_tick",   int'(bus.turn_tick),    0);
    chk("rst_stall",  int'(bus.stall),        1);
    chk("rst_valid",  int'(bus.period_valid), 0);
    chk("rst_period", int'(bus.turn_period),  0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk_exp(1 + LAT, 0, 0));
    wait_cyc(LAT);
    chk("post_rst_stall_before", int'(bus.stall), 1);
    wait_cyc(LAT + 2);
    chk("post_rst_stall_after", int'(bus.stall),        0);
    chk("post_rst_valid_after", int'(bus.period_valid), 0);
    wait_cyc(30);
    bus.hall_n = 1'b1;
    wait_cyc(60);
    chk("missing_ticks_rst", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hall_tick_gen.md
HALL_TICK_GEN -- requirements
Module: hall_tick_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: metastability flops on hall_n, minimum 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 256: consecutive stable samples required to accept a level change, minimum 1.
REQ-003 Parameter MIN_PERIOD, default 4096: minimum cycles between accepted ticks; closer edges are rejected as glitches.
REQ-004 Parameter PERIOD_WIDTH, default 24: width of the period counter and of turn_period.
REQ-005 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port hall_n, input, 1: raw hall sensor, asynchronous to clk; low means magnet present.
REQ-008 Port turn_tick, output, 1: one-cycle pulse per accepted turn; feeds the synchronizer turn_tick input.
REQ-009 Port turn_period, output, PERIOD_WIDTH: clk cycles between the last two accepted ticks.
REQ-010 Port period_valid, output, 1: turn_period holds a valid measurement.
REQ-011 Port stall, output, 1: no accepted tick for 2^PERIOD_WIDTH-1 cycles, or no tick yet since reset.

Function
REQ-012 hall_n shall pass through SYNC_STAGES flops before any use; hs is the last stage.
REQ-013 FSM states shall be REL (released), DB_ACT (debouncing assert), ACT (active), and DB_REL (debouncing release).
REQ-014 REL shall go to DB_ACT when hs=0; otherwise it stays in REL.
REQ-015 DB_ACT shall count cycles with hs=0 and return to REL on any hs=1 sample.
REQ-016 DB_ACT shall go to ACT when its count reaches DEBOUNCE_CYCLES.
REQ-017 ACT shall go to DB_REL when hs=1, and DB_REL shall go to REL after DEBOUNCE_CYCLES consecutive hs=1 samples.
REQ-018 DB_REL shall return to ACT on any hs=0 sample.
REQ-019 Tick candidate: the REL->...->ACT transition shall be evaluated in the DB_ACT->ACT cycle.
REQ-020 A candidate shall be accepted when stall=1 or pcnt+1 >= MIN_PERIOD.
REQ-021 An accepted candidate shall drive turn_tick=1 in the following cycle.
REQ-022 A rejected candidate shall still enter ACT but produce no tick and leave pcnt, turn_period and period_valid unchanged.
REQ-023 Latency: a hall_n low level held stable shall produce turn_tick exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the first clk edge that samples it low.
REQ-024 pcnt (PERIOD_WIDTH bits) shall increment every cycle and saturate at all-ones; it shall clear to 0 in the turn_tick cycle.
REQ-025 On an accepted tick with stall=0, turn_period shall load pcnt+1 (the cycle distance between ticks) and period_valid shall be set.
REQ-026 On an accepted tick with stall=1, turn_period shall be unchanged, period_valid shall stay 0, and stall shall clear.
REQ-027 When pcnt reaches all-ones, stall shall be set and period_valid cleared in the same cycle; turn_period keeps its last value.
REQ-028 turn_tick shall never assert on two consecutive cycles.
REQ-029 Consecutive ticks shall be at least max(MIN_PERIOD, 2*DEBOUNCE_CYCLES+2) cycles apart.

Reset
REQ-030 While rst=0: sync flops=1, FSM=REL, debounce count=0, pcnt=0, turn_tick=0, turn_period=0, period_valid=0, stall=1.
REQ-031 Reset mid-debounce or mid-turn shall abort the event with no tick emitted.
REQ-032 After release of reset, the first accepted tick shall only arm measurement (see REQ-026).

Structure
REQ-033 The FSM state enum shall live in the shared synchronizer package (syncro_pkg).
REQ-034 The hall polarity constant HALL_ACTIVE=0 shall also live in syncro_pkg.
REQ-035 The synchronizer flop chain shall be one sub-module, sync_ff, parameterised by SYNC_STAGES, reusable for force_fc.
REQ-036 The RTL shall contain no latches and no derived clocks.

Verification (bench: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MIN_PERIOD=100, PERIOD_WIDTH=10)
REQ-037 Reset released, hall_n low at cycle 10 and held -> turn_tick at cycle 17 only; period_valid=0; stall 1->0.
REQ-038 Clean pulses every 500 cycles, each 50 cycles wide -> one tick per pulse; after the second tick turn_period=500 and period_valid=1.
REQ-039 3-cycle low glitches and bounce (low 3, high 1, low 3) -> no tick; FSM returns to REL.
REQ-040 Second valid pulse only 60 cycles after an accepted tick -> rejected; turn_period and pcnt unchanged.
REQ-041 No pulse for 1023 cycles after a tick -> stall=1 and period_valid=0; the next pulse ticks without updating turn_period.
REQ-042 rst pulled low during DB_ACT count=3 -> all outputs at reset values; no tick after release until a new full debounce completes.
